// File: rtl/data_memory_mmio.sv
// Word RAM plus MMIO page (TX byte FIFO, STATUS, optional CYCLES counter); reads are combinational.
// Define MMIO_CYCLE_COUNTER_EN to include the free-running CYCLES register at offset 0x08.
module data_memory_mmio #(
    parameter int RAM_WORDS  = 256,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_write,
    input  logic [23:0] address,
    input  logic [23:0] write_data,
    output logic [23:0] read_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);
    localparam int AW = $clog2(RAM_WORDS);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [24:0] RAM_BYTES = 25'(RAM_WORDS * 4);
    localparam logic [7:0] OFF_TX     = 8'h00;
    localparam logic [7:0] OFF_STATUS = 8'h04;
    localparam logic [7:0] OFF_CYCLES = 8'h08;

    logic [23:0] ram [RAM_WORDS];
    logic [7:0]  fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          ovf;

    logic ram_hit, mmio_hit, empty, full, push_req, push_ok, pop;
    logic [7:0]  offset;
    logic [23:0] status;
    logic [23:0] cycles;
    logic        unused_bits;

    assign ram_hit  = ({1'b0, address} < RAM_BYTES);
    assign mmio_hit = (address[23:8] == 16'hFFFF);
    assign offset   = address[7:0];

    assign empty    = (count == '0);
    assign full     = (count == (PW+1)'(FIFO_DEPTH));
    assign tx_valid = !empty;
    assign tx_data  = empty ? 8'h00 : fifo_mem[rd_ptr];
    assign pop      = tx_valid && tx_ready;
    assign push_req = mem_write && mmio_hit && (offset == OFF_TX);
    // A push into a full FIFO is still accepted when the head leaves in the same cycle.
    assign push_ok  = push_req && (!full || pop);
    assign status   = {16'b0, 4'(count), 1'b0, ovf, full, empty};

    assign unused_bits = ^{address[1:0], write_data[23:8]};

    always_ff @(posedge clk) begin
        if (!rst && mem_write && ram_hit) begin
            ram[address[AW+1:2]] <= write_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            fifo_mem[wr_ptr] <= write_data[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PW'(1);
            if (pop)     rd_ptr <= rd_ptr + PW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + (PW+1)'(1);
                2'b01:   count <= count - (PW+1)'(1);
                default: count <= count;
            endcase
            if (push_req && full && !pop) begin
                ovf <= 1'b1;
            end else if (mem_write && mmio_hit && (offset == OFF_STATUS) && write_data[2]) begin
                ovf <= 1'b0;
            end
        end
    end

`ifdef MMIO_CYCLE_COUNTER_EN
    logic [23:0] counter;

    always_ff @(posedge clk) begin
        if (rst) begin
            counter <= '0;
        end else if (mem_write && mmio_hit && (offset == OFF_CYCLES)) begin
            counter <= write_data;
        end else begin
            counter <= counter + 24'd1;
        end
    end

    assign cycles = counter;
`else
    assign cycles = 24'h000000;
`endif

    always_comb begin
        read_data = 24'h000000;
        if (ram_hit) begin
            read_data = ram[address[AW+1:2]];
        end else if (mmio_hit) begin
            case (offset)
                OFF_STATUS: read_data = status;
                OFF_CYCLES: read_data = cycles;
                default:    read_data = 24'h000000;
            endcase
        end
    end
endmodule

// File: tb/tb_data_memory_mmio.sv
// Directed bench for data_memory_mmio: RAM, unmapped space, TX FIFO, STATUS, CYCLES and reset.
module tb_data_memory_mmio;
    logic        clk = 1'b0;
    logic        rst;
    logic        mem_write;
    logic [23:0] address;
    logic [23:0] write_data;
    logic [23:0] read_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [23:0] A_TX     = 24'hFFFF00;
    localparam logic [23:0] A_STATUS = 24'hFFFF04;
    localparam logic [23:0] A_CYCLES = 24'hFFFF08;

    data_memory_mmio dut (
        .clk        (clk),
        .rst        (rst),
        .mem_write  (mem_write),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %06h expected %06h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [23:0] a, input logic [23:0] d);
        address    = a;
        write_data = d;
        mem_write  = 1'b1;
        tick();
        mem_write  = 1'b0;
    endtask

    task automatic load(input logic [23:0] a);
        mem_write = 1'b0;
        address   = a;
        #1;
    endtask

    initial begin
        rst = 1'b1; mem_write = 1'b0; address = '0; write_data = '0; tx_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;

        load(A_STATUS);
        check("reset_status", read_data, 24'h000001);
        check("reset_tx_valid", {23'b0, tx_valid}, 24'h000000);
        check("reset_tx_data", {16'b0, tx_data}, 24'h000000);

        // RAM
        store(24'h000014, 24'h000ABC);
        store(24'h000010, 24'h123456);
        load(24'h000010);
        check("ram_load_10", read_data, 24'h123456);
        load(24'h000013);
        check("ram_low_bits_ignored", read_data, 24'h123456);
        load(24'h000014);
        check("ram_load_14", read_data, 24'h000ABC);

        // Unmapped space, including the first byte past RAM
        store(24'h000000, 24'h000111);
        store(24'h800000, 24'hFFFFFF);
        store(24'h000400, 24'h777777);
        load(24'h800000);
        check("unmapped_800000", read_data, 24'h000000);
        load(24'h000400);
        check("unmapped_400", read_data, 24'h000000);
        load(24'h000000);
        check("ram_no_alias_0", read_data, 24'h000111);
        load(24'h000010);
        check("ram_after_unmapped", read_data, 24'h123456);
        load(24'hFFFF0C);
        check("mmio_other_offset", read_data, 24'h000000);

        // FIFO fill, overflow, drain
        tx_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            address = A_TX; write_data = 24'h000041 + 24'(i); mem_write = 1'b1;
            #1;
            if (i == 0) check("no_same_cycle_bypass", {23'b0, tx_valid}, 24'h000000);
            tick();
        end
        mem_write = 1'b0;
        load(A_STATUS);
        check("fifo_full_status", read_data, 24'h000082);
        check("fifo_head", {16'b0, tx_data}, 24'h000041);
        store(A_TX, 24'h000049);
        load(A_STATUS);
        check("fifo_ovf_status", read_data, 24'h000086);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("drain_valid", {23'b0, tx_valid}, 24'h000001);
            check("drain_data", {16'b0, tx_data}, 24'h000041 + 24'(i));
            tick();
        end
        tx_ready = 1'b0;
        load(A_STATUS);
        check("drained_valid", {23'b0, tx_valid}, 24'h000000);
        check("drained_status", read_data, 24'h000005);
        store(A_STATUS, 24'h000004);
        load(A_STATUS);
        check("ovf_cleared", read_data, 24'h000001);

        // Full with simultaneous pop and push
        for (int i = 0; i < 8; i++) store(A_TX, 24'h000050 + 24'(i));
        tx_ready = 1'b1;
        store(A_TX, 24'h00005A);
        tx_ready = 1'b0;
        load(A_STATUS);
        check("full_pushpop_status", read_data, 24'h000082);
        check("full_pushpop_head", {16'b0, tx_data}, 24'h000051);
        tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("pushpop_drain", {16'b0, tx_data}, (i == 7) ? 24'h00005A : 24'h000051 + 24'(i));
            tick();
        end
        tx_ready = 1'b0;
        load(A_STATUS);
        check("pushpop_empty", read_data, 24'h000001);

        // Cycle counter
        store(A_CYCLES, 24'hFFFFFE);
        load(A_CYCLES);
`ifdef MMIO_CYCLE_COUNTER_EN
        check("cycles_loaded", read_data, 24'hFFFFFE);
        tick();
        check("cycles_plus1", read_data, 24'hFFFFFF);
        tick();
        check("cycles_wrap", read_data, 24'h000000);
`else
        check("cycles_absent", read_data, 24'h000000);
        tick();
        check("cycles_absent_later", read_data, 24'h000000);
`endif

        // Reset mid-stream; store during reset must be ignored
        store(24'h000020, 24'hABCDEF);
        store(A_TX, 24'h000061);
        store(A_TX, 24'h000062);
        store(A_TX, 24'h000063);
        load(A_STATUS);
        check("pre_reset_status", read_data, 24'h000030);
        rst = 1'b1;
        address = 24'h000020; write_data = 24'h111111; mem_write = 1'b1;
        tick();
        rst = 1'b0; mem_write = 1'b0;
        load(A_STATUS);
        check("post_reset_status", read_data, 24'h000001);
        check("post_reset_valid", {23'b0, tx_valid}, 24'h000000);
        check("post_reset_data", {16'b0, tx_data}, 24'h000000);
        load(A_CYCLES);
        check("post_reset_cycles", read_data, 24'h000000);
        load(24'h000020);
        check("ram_survives_reset", read_data, 24'hABCDEF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
